// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter/sequencer sharing one SPI master between nreqs requesters.
// Caches the last programmed packet size so repeated sizes skip the size handshake.
module spi_master_arbiter #(
    parameter int nbits = 34,
    parameter int nreqs = 2,
    localparam int sbits = $clog2(nbits),
    localparam int ibits = $clog2(nreqs)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [nreqs-1:0]        req_val,
    output logic [nreqs-1:0]        req_rdy,
    input  logic [nreqs*nbits-1:0]  req_msg,
    input  logic [nreqs*sbits-1:0]  req_size,
    output logic [nreqs-1:0]        resp_val,
    input  logic [nreqs-1:0]        resp_rdy,
    output logic [nbits-1:0]        resp_msg,
    output logic                    packet_size_ifc_val,
    input  logic                    packet_size_ifc_rdy,
    output logic [sbits-1:0]        packet_size_ifc_msg,
    output logic                    spi_recv_val,
    input  logic                    spi_recv_rdy,
    output logic [nbits-1:0]        spi_recv_msg,
    input  logic                    spi_send_val,
    output logic                    spi_send_rdy,
    input  logic [nbits-1:0]        spi_send_msg,
    output logic [ibits-1:0]        grant_idx,
    output logic                    busy
);

    typedef enum logic [1:0] {IDLE, SIZE, DATA, RESP} state_t;

    state_t            state, state_nxt;
    logic [ibits-1:0]  ptr;
    logic              size_vld;
    logic [sbits-1:0]  size_cache;
    logic [sbits-1:0]  size_q;
    logic [nbits-1:0]  msg_q;

    logic              win_found;
    logic [ibits-1:0]  win_idx;
    logic [sbits-1:0]  win_size;
    logic [nbits-1:0]  win_msg;
    int unsigned       cand;
    logic              resp_fire;

    // First valid requester at or after ptr, wrapping around.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int unsigned k = 0; k < nreqs; k++) begin
            cand = (32'(ptr) + k) % nreqs;
            if (!win_found && req_val[cand]) begin
                win_found = 1'b1;
                win_idx   = ibits'(cand);
            end
        end
        win_msg  = req_msg[int'(win_idx)*nbits +: nbits];
        win_size = req_size[int'(win_idx)*sbits +: sbits];
    end

    assign resp_fire = (state == RESP) && spi_send_val && resp_rdy[grant_idx];

    always_comb begin
        state_nxt           = state;
        req_rdy             = '0;
        resp_val            = '0;
        packet_size_ifc_val = 1'b0;
        spi_recv_val        = 1'b0;
        spi_send_rdy        = 1'b0;
        case (state)
            IDLE: begin
                if (win_found) begin
                    req_rdy[win_idx] = 1'b1;
                    state_nxt = (size_vld && (win_size == size_cache)) ? DATA : SIZE;
                end
            end
            SIZE: begin
                packet_size_ifc_val = 1'b1;
                if (packet_size_ifc_rdy) state_nxt = DATA;
            end
            DATA: begin
                spi_recv_val = 1'b1;
                if (spi_recv_rdy) state_nxt = RESP;
            end
            RESP: begin
                spi_send_rdy        = resp_rdy[grant_idx];
                resp_val[grant_idx] = spi_send_val;
                if (resp_fire) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign packet_size_ifc_msg = size_q;
    assign spi_recv_msg        = msg_q;
    assign resp_msg            = spi_send_msg;
    assign busy                = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            ptr        <= '0;
            grant_idx  <= '0;
            size_vld   <= 1'b0;
            size_cache <= '0;
            size_q     <= '0;
            msg_q      <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && win_found) begin
                msg_q     <= win_msg;
                size_q    <= win_size;
                grant_idx <= win_idx;
            end
            if (state == SIZE && packet_size_ifc_rdy) begin
                size_cache <= size_q;
                size_vld   <= 1'b1;
            end
            if (resp_fire) begin
                ptr <= (int'(grant_idx) == nreqs - 1) ? '0 : grant_idx + 1'b1;
            end
        end
    end

endmodule
